// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared alucontrol encodings, FSM states and requester count
package alu_arbiter_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alucontrol_e;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: combinational ALU; op codes 110/111 are illegal and yield zero with err
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic              err
);
  // operation select; anything past SLT falls through to zero
  always_comb begin
    y    = op == ALU_ADD ? a + b :
           op == ALU_SUB ? a - b :
           op == ALU_AND ? a & b :
           op == ALU_OR  ? a | b :
           op == ALU_XOR ? a ^ b :
           op == ALU_SLT ? {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)} : '0;
    zero = y == '0;
    err  = op[2] & op[1];
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one alu via a single-entry response register; define ALU_ARBITER_ROUND_ROBIN_EN for round-robin contention (default fixed priority, requester 0 wins)
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_b,
  input  logic [NUM_REQ-1:0][2:0]          req_op,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_W-1:0]                rsp_result,
  output logic                             rsp_zero,
  output logic                             rsp_id,
  output logic                             rsp_err
);
  state_e            state_q, state_d;
  logic              gnt, slot_free, xfer;
  logic [DATA_W-1:0] alu_y, result_q;
  logic              alu_zero, alu_err, zero_q, id_q, err_q;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  // contention goes to the favoured requester; a lone requester always wins
  always_comb begin
    gnt   = &req_valid ? ptr_q : !req_valid[0];
    ptr_d = xfer ? !gnt : ptr_q;
  end
  // pointer moves only on a transfer, favouring the requester not just served
  always_ff @(posedge clk) ptr_q <= reset ? 1'b0 : ptr_d;
`else
  // fixed priority: requester 0 wins whenever it is valid
  always_comb gnt = !req_valid[0];
`endif
  // handshake and next state; slot frees the same cycle the consumer drains it
  always_comb begin
    slot_free = state_q == EMPTY || rsp_ready;
    req_ready = (!reset && slot_free && req_valid[gnt]) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    xfer      = |req_ready;
    state_d   = xfer ? FULL : (state_q == FULL && !rsp_ready) ? FULL : EMPTY;
  end
  alu #(.DATA_W(DATA_W)) u_alu (
    .a    (req_a[gnt]),
    .b    (req_b[gnt]),
    .op   (req_op[gnt]),
    .y    (alu_y),
    .zero (alu_zero),
    .err  (alu_err)
  );
  // response register loads on a transfer and otherwise holds
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      result_q <= '0;
      zero_q   <= 1'b0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        result_q <= alu_y;
        zero_q   <= alu_zero;
        id_q     <= gnt;
        err_q    <= alu_err;
      end
    end
  end
  assign rsp_valid  = state_q == FULL;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_id     = id_q;
  assign rsp_err    = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (honours ALU_ARBITER_ROUND_ROBIN_EN)
module tb_alu_arbiter;
  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a, req_b;
  logic [1:0][2:0]  req_op;
  logic             rsp_valid, rsp_ready, rsp_zero, rsp_id, rsp_err;
  logic [31:0]      rsp_result;
  int               checks = 0;
  int               failures = 0;
  logic [3:0]       exp_ids;
  alu_arbiter #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rsp(input string tag, input logic v, input logic [31:0] r, input logic z, input logic id, input logic e);
    chk({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({tag, ".result"}, rsp_result, r);
    chk({tag, ".zero"}, {31'd0, rsp_zero}, {31'd0, z});
    chk({tag, ".id"}, {31'd0, rsp_id}, {31'd0, id});
    chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, e});
  endtask
  initial begin
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    #1;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    step(); step();
    rsp("rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_ready2", {30'd0, req_ready}, 32'd0);
    reset = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    step();
    chk("empty_ready_noeffect", {31'd0, rsp_valid}, 32'd0);
    req_valid = 2'b01; req_a[0] = 32'd10; req_b[0] = 32'd15; req_op[0] = 3'b000;
    #1 chk("add_ready", {30'd0, req_ready}, 32'd1);
    step();
    rsp("add", 1'b1, 32'd25, 1'b0, 1'b0, 1'b0);
    req_valid = 2'b10; req_a[1] = 32'd42; req_b[1] = 32'd42; req_op[1] = 3'b001;
    #1 chk("sub_ready", {30'd0, req_ready}, 32'd2);
    step();
    rsp("sub0", 1'b1, 32'd0, 1'b1, 1'b1, 1'b0);
    req_a[1] = 32'd0; req_b[1] = 32'd1;
    step();
    rsp("subwrap", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    req_valid = 2'b00;
    step();
    chk("drain", {31'd0, rsp_valid}, 32'd0);
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    req_valid = 2'b11;
    req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = 3'b000;
    req_a[1] = 32'hF0; req_b[1] = 32'h3C; req_op[1] = 3'b100;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("cont%0d_ready", i), {30'd0, req_ready}, exp_ids[i] ? 32'd2 : 32'd1);
      step();
      rsp($sformatf("cont%0d", i), 1'b1, exp_ids[i] ? 32'hCC : 32'd2, 1'b0, exp_ids[i], 1'b0);
    end
    req_valid = 2'b00;
    step();
    req_valid = 2'b01; req_a[0] = 32'd5; req_b[0] = 32'd10; req_op[0] = 3'b101; rsp_ready = 1'b0;
    #1 chk("slt_ready", {30'd0, req_ready}, 32'd1);
    step();
    rsp("slt", 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    req_a[0] = 32'd7; req_b[0] = 32'd1; req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("stall%0d_ready", i), {30'd0, req_ready}, 32'd0);
      step();
      rsp($sformatf("stall%0d", i), 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    step();
    chk("stall_drain", {31'd0, rsp_valid}, 32'd0);
    req_valid = 2'b01; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd1; req_op[0] = 3'b101;
    step();
    rsp("slt_neg", 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    req_a[0] = 32'd1; req_b[0] = 32'hFFFF_FFFF;
    step();
    rsp("slt_pos", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    req_a[0] = 32'hF0F0; req_b[0] = 32'h0FF0; req_op[0] = 3'b010;
    step();
    rsp("and", 1'b1, 32'h00F0, 1'b0, 1'b0, 1'b0);
    req_op[0] = 3'b011;
    step();
    rsp("or", 1'b1, 32'hFFF0, 1'b0, 1'b0, 1'b0);
    req_a[0] = 32'd7; req_b[0] = 32'd3; req_op[0] = 3'b111;
    step();
    rsp("illegal7", 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    req_valid = 2'b10; req_a[1] = 32'd9; req_b[1] = 32'd9; req_op[1] = 3'b110;
    step();
    rsp("illegal6", 1'b1, 32'd0, 1'b1, 1'b1, 1'b1);
    req_valid = 2'b01; req_op[0] = 3'b000;
    step();
    rsp("pre_reset", 1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
    req_valid = 2'b11; rsp_ready = 1'b0; reset = 1'b1;
    #1 chk("midrst_ready", {30'd0, req_ready}, 32'd0);
    step();
    rsp("midrst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1 chk("postrst_ready", {30'd0, req_ready}, 32'd1);
    step();
    rsp("postrst", 1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  [1:0]  per-requester request valid.
REQ-005 req_ready  output  [1:0]  per-requester accept; at most one bit high per cycle.
REQ-006 req_a  input  [1:0][DATA_W-1:0]  operand A per requester.
REQ-007 req_b  input  [1:0][DATA_W-1:0]  operand B per requester.
REQ-008 req_op  input  [1:0][2:0]  alucontrol code per requester.
REQ-009 rsp_valid  output  1  response register holds a result.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_result  output  DATA_W  registered ALU result.
REQ-012 rsp_zero  output  1  registered result==0 flag.
REQ-013 rsp_id  output  1  index of the requester that issued the response.
REQ-014 rsp_err  output  1  request carried an illegal op code.

Function
REQ-015 The block SHALL share one combinational alu instance between two requesters through a single-entry response register.
REQ-016 The FSM SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 Slot free SHALL be defined as EMPTY, or FULL with rsp_ready=1 in the same cycle.
REQ-018 req_ready[i] SHALL be high only when slot free, req_valid[i]=1 and requester i holds the grant.
REQ-019 A transfer SHALL occur on req_valid[i] & req_ready[i]; the result SHALL be registered at that edge, with rsp_valid high the next cycle (latency 1).
REQ-020 Ops SHALL be: 000 add mod 2^DATA_W; 001 sub, two's-complement wrap; 010 and; 011 or; 100 xor; 101 signed set-less-than giving 1 or 0.
REQ-021 Ops 110/111 SHALL register rsp_result=0, rsp_zero=1, rsp_err=1, and SHALL still produce a response.
REQ-022 rsp_zero SHALL equal (rsp_result==0) for every response.
REQ-023 While rsp_valid=1 and rsp_ready=0, all rsp_* outputs SHALL hold stable and both req_ready bits SHALL be 0.
REQ-024 FULL with rsp_ready=1 and a new transfer SHALL stay FULL with the new result, with no bubble.
REQ-025 FULL with rsp_ready=1 and no transfer SHALL go EMPTY.
REQ-026 With only one requester valid, that requester SHALL be granted regardless of arbitration history.
REQ-027 rsp_ready asserted while EMPTY SHALL have no effect.

Reset
REQ-028 While reset=1 at a clock edge: rsp_valid, rsp_result, rsp_zero, rsp_id and rsp_err SHALL all be 0, and the FSM SHALL be EMPTY.
REQ-029 req_ready SHALL be 0 in any cycle where reset=1.
REQ-030 Reset mid-operation SHALL discard any held response without signalling it.
REQ-031 The arbitration pointer SHALL reset so that requester 0 wins the first contention.

Configuration
REQ-032 With ALU_ARBITER_ROUND_ROBIN_EN defined, contention SHALL be round-robin.
REQ-033 In that mode, the pointer SHALL favour the requester not granted last and SHALL update only on a transfer.
REQ-034 Without ALU_ARBITER_ROUND_ROBIN_EN, requester 0 SHALL always win contention (fixed priority) and the pointer register SHALL not exist.

Structure
REQ-035 A shared package alu_arbiter_pkg SHALL hold: alucontrol encodings (ALU_ADD..ALU_SLT) as a 3-bit typedef, the state enum, and the requester count constant (2).
REQ-036 The existing alu module SHALL be the only sub-module; arbitration and FSM logic SHALL remain inline.

Verification
REQ-037 Req0 a=10 b=15 op=000, rsp_ready=1 -> next cycle rsp_valid=1, result=25, zero=0, id=0.
REQ-038 Req1 a=42 b=42 op=001 -> result=0, zero=1, id=1; a=0 b=1 op=001 -> result=FFFFFFFF.
REQ-039 Both valid for 4 transfers, rsp_ready=1 -> ids 0,1,0,1 with the macro; ids 0,0,0,0 without it.
REQ-040 rsp_ready=0 for 3 cycles after req0 a=5 b=10 op=101 -> result=1 held stable, req_ready=00 throughout, then drains.
REQ-041 op=111 a=7 b=3 -> result=0, zero=1, err=1.
REQ-042 Reset asserted while FULL -> rsp_valid=0 next cycle; the following contention grants requester 0.
